ycbcr_frame_ctrl: RTL and testbench

YCBCR_FRAME_CTRL -- requirements
Module: ycbcr_frame_ctrl

---
 rtl/ycbcr_frame_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ycbcr_frame_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_frame_ctrl.sv
// ycbcr_frame_ctrl
//   Capture controller sitting in front of the RGB-to-YCbCr converter.
//   It arms on a start pulse, waits for the next VSYNC rising edge, then
//   forwards VSYNC/DVALID to the converter through one register stage.
//   While forwarding, it counts pixels per line and lines per frame.
//   After the last line, or after a premature VSYNC, it drains the converter
//   pipeline and reports the frame as done or errored.
//
// Ports
//   RGB_CLK      pixel clock, rising edge
//   RESET        async, active-low reset
//   CAP_START    pulse: arm capture (CAP_SINGLE sampled with it)
//   CAP_STOP     pulse: stop (immediately in ARM, after current frame otherwise)
//   CAP_SINGLE   1 = one frame, 0 = continuous
//   IN_VSYNC     raw stream vsync
//   IN_DVALID    raw stream data valid
//   CONV_VSYNC   gated, 1-cycle delayed vsync to converter
//   CONV_DVALID  gated, 1-cycle delayed dvalid to converter
//   BUSY         state != IDLE
//   FRAME_DONE   1-cycle pulse at end of drain
//   FRAME_ERR    1-cycle pulse with FRAME_DONE when the frame was malformed
//   FRAME_CNT    completed frame counter (wraps)
module ycbcr_frame_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CW    = 12
) (
  input  logic        RGB_CLK,
  input  logic        RESET,
  input  logic        CAP_START,
  input  logic        CAP_STOP,
  input  logic        CAP_SINGLE,
  input  logic        IN_VSYNC,
  input  logic        IN_DVALID,
  output logic        CONV_VSYNC,
  output logic        CONV_DVALID,
  output logic        BUSY,
  output logic        FRAME_DONE,
  output logic        FRAME_ERR,
  output logic [15:0] FRAME_CNT
);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DRAIN} state_t;

  localparam logic [CW-1:0] H_LEN   = CW'(H_ACT);
  localparam logic [CW-1:0] V_LEN   = CW'(V_ACT);
  localparam logic [CW-1:0] PIX_MAX = '1;
  localparam logic [CW-1:0] ONE     = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [CW-1:0] line_cnt_q, line_cnt_d;
  logic          err_q, err_d;
  logic          stop_q, stop_d;
  logic          single_q, single_d;
  logic [1:0]    drain_q, drain_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          vs_prev_q, dv_prev_q;
  logic          conv_vs_q, conv_dv_q;
  logic          fwd;

  // Edge detectors run in every state so that a VSYNC already high at arm
  // time is not mistaken for a fresh frame start.
  logic vs_rise, dv_fall;
  assign vs_rise = IN_VSYNC & ~vs_prev_q;
  assign dv_fall = ~IN_DVALID & dv_prev_q;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    err_d      = err_q;
    stop_d     = stop_q;
    single_d   = single_q;
    drain_d    = drain_q;
    fcnt_d     = fcnt_q;
    fwd        = 1'b0;
    FRAME_DONE = 1'b0;
    FRAME_ERR  = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous start and stop cancel each other.
        if (CAP_START && !CAP_STOP) begin
          state_d  = ARM;
          single_d = CAP_SINGLE;
          stop_d   = 1'b0;
        end
      end
      ARM: begin
        if (CAP_STOP) begin
          state_d = IDLE;
        end else if (vs_rise) begin
          state_d    = ACTIVE;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          err_d      = 1'b0;
          fwd        = 1'b1;
        end
      end
      ACTIVE: begin
        if (CAP_STOP) stop_d = 1'b1;
        // The VSYNC that ends a short frame belongs to the next frame,
        // so it is held back from the converter.
        fwd = ~vs_rise;
        if (IN_DVALID && pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + ONE;
        if (dv_fall) begin
          if (pix_cnt_q != H_LEN) err_d = 1'b1;
          pix_cnt_d  = '0;
          line_cnt_d = line_cnt_q + ONE;
        end
        if (dv_fall && (line_cnt_q + ONE) == V_LEN) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end else if (vs_rise) begin
          state_d = DRAIN;
          drain_d = 2'd0;
          err_d   = 1'b1;
        end
      end
      DRAIN: begin
        // 1 gating stage + 3 converter stages must flush before reporting.
        if (CAP_STOP) stop_d = 1'b1;
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          FRAME_DONE = 1'b1;
          FRAME_ERR  = err_q;
          fcnt_d     = fcnt_q + 16'd1;
          state_d    = (single_q || stop_q || CAP_STOP) ? IDLE : ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge RGB_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      err_q      <= 1'b0;
      stop_q     <= 1'b0;
      single_q   <= 1'b0;
      drain_q    <= 2'd0;
      fcnt_q     <= 16'd0;
      vs_prev_q  <= 1'b0;
      dv_prev_q  <= 1'b0;
      conv_vs_q  <= 1'b0;
      conv_dv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      err_q      <= err_d;
      stop_q     <= stop_d;
      single_q   <= single_d;
      drain_q    <= drain_d;
      fcnt_q     <= fcnt_d;
      vs_prev_q  <= IN_VSYNC;
      dv_prev_q  <= IN_DVALID;
      conv_vs_q  <= fwd & IN_VSYNC;
      conv_dv_q  <= fwd & IN_DVALID;
    end
  end

  assign CONV_VSYNC  = conv_vs_q;
  assign CONV_DVALID = conv_dv_q;
  assign BUSY        = (state_q != IDLE);
  assign FRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Scoreboard bench for ycbcr_frame_ctrl with H_ACT=4, V_ACT=2.
// Each driven cycle pushes the expected converter-side outputs for that
// cycle; they are popped and compared one clock later.
module tb_ycbcr_frame_ctrl;
  logic        RGB_CLK = 1'b0;
  logic        RESET;
  logic        CAP_START, CAP_STOP, CAP_SINGLE;
  logic        IN_VSYNC, IN_DVALID;
  logic        CONV_VSYNC, CONV_DVALID, BUSY, FRAME_DONE, FRAME_ERR;
  logic [15:0] FRAME_CNT;

  ycbcr_frame_ctrl #(.H_ACT(4), .V_ACT(2), .CW(12)) dut (
    .RGB_CLK(RGB_CLK), .RESET(RESET),
    .CAP_START(CAP_START), .CAP_STOP(CAP_STOP), .CAP_SINGLE(CAP_SINGLE),
    .IN_VSYNC(IN_VSYNC), .IN_DVALID(IN_DVALID),
    .CONV_VSYNC(CONV_VSYNC), .CONV_DVALID(CONV_DVALID), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 RGB_CLK = ~RGB_CLK;

  typedef struct packed {logic vs; logic dv; logic done; logic err;} exp_t;
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ctl = {single, stop, start}
  task automatic step(input logic vs, input logic dv, input logic fwd,
                      input logic done = 1'b0, input logic err = 1'b0,
                      input logic [2:0] ctl = 3'b000);
    exp_t e;
    @(negedge RGB_CLK);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("conv_vsync",  {31'd0, CONV_VSYNC},  {31'd0, e.vs});
      chk("conv_dvalid", {31'd0, CONV_DVALID}, {31'd0, e.dv});
      chk("frame_done",  {31'd0, FRAME_DONE},  {31'd0, e.done});
      chk("frame_err",   {31'd0, FRAME_ERR},   {31'd0, e.err});
    end
    IN_VSYNC   = vs;
    IN_DVALID  = dv;
    CAP_START  = ctl[0];
    CAP_STOP   = ctl[1];
    CAP_SINGLE = ctl[2];
    sbq.push_back('{vs & fwd, dv & fwd, done, err});
  endtask

  // One frame: vsync pulse, line 0 of l0 pixels, then either line 1 of l1
  // pixels or (shrt) a premature vsync. Drain tail: done on the 3rd cycle
  // after the closing event, plus 2 cycles so FRAME_CNT is settled on return.
  task automatic frame(input int l0, input int l1, input logic fwd,
                       input logic shrt, input logic err,
                       input logic dvs = 1'b0, input logic [2:0] cmid = 3'b000);
    step(1, 0, fwd);
    step(0, 0, fwd);
    step(0, 0, fwd);
    for (int p = 0; p < l0; p++) step(0, 1, fwd, 0, 0, (p == 1) ? cmid : 3'b000);
    step(0, 0, fwd);
    step(0, 0, fwd);
    if (shrt) begin
      step(1, 0, 0);
    end else begin
      for (int p = 0; p < l1; p++) step(0, 1, fwd);
      step(0, 0, fwd);
    end
    step(dvs, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0, fwd, fwd & err);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic do_reset();
    #1 RESET = 1'b0;
    #1;
    chk("rst_conv_vsync",  {31'd0, CONV_VSYNC},  32'd0);
    chk("rst_conv_dvalid", {31'd0, CONV_DVALID}, 32'd0);
    chk("rst_busy",        {31'd0, BUSY},        32'd0);
    chk("rst_frame_done",  {31'd0, FRAME_DONE},  32'd0);
    chk("rst_frame_err",   {31'd0, FRAME_ERR},   32'd0);
    chk("rst_frame_cnt",   {16'd0, FRAME_CNT},   32'd0);
    sbq.delete();
    IN_VSYNC = 0; IN_DVALID = 0; CAP_START = 0; CAP_STOP = 0; CAP_SINGLE = 0;
    repeat (2) @(posedge RGB_CLK);
    @(negedge RGB_CLK);
    RESET = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0;
    IN_VSYNC = 0; IN_DVALID = 0; CAP_START = 0; CAP_STOP = 0; CAP_SINGLE = 0;
    do_reset();

    // Single good frame
    step(0, 0, 0, 0, 0, 3'b101);
    frame(4, 4, 1, 0, 0);
    chk("single_cnt",  {16'd0, FRAME_CNT}, 32'd1);
    chk("single_busy", {31'd0, BUSY},      32'd0);

    // Traffic while idle, then arm in the middle of a frame
    frame(4, 4, 0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0, 0, 0, 3'b101);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("prearm_busy", {31'd0, BUSY}, 32'd1);
    frame(4, 4, 1, 0, 0);
    chk("prearm_cnt", {16'd0, FRAME_CNT}, 32'd2);

    // Bad line length
    step(0, 0, 0, 0, 0, 3'b101);
    frame(4, 3, 1, 0, 1);
    chk("badline_cnt", {16'd0, FRAME_CNT}, 32'd3);

    // Short frame: vsync after one line
    step(0, 0, 0, 0, 0, 3'b101);
    frame(4, 4, 1, 1, 1);
    chk("short_cnt",  {16'd0, FRAME_CNT}, 32'd4);
    chk("short_busy", {31'd0, BUSY},      32'd0);

    // Continuous: 3 frames, vsync in drain ignored, stop in frame 3
    do_reset();
    step(0, 0, 0, 0, 0, 3'b001);
    frame(4, 4, 1, 0, 0, 1);
    chk("cont_busy1", {31'd0, BUSY},      32'd1);
    chk("cont_cnt1",  {16'd0, FRAME_CNT}, 32'd1);
    frame(4, 4, 1, 0, 0);
    frame(4, 4, 1, 0, 0, 0, 3'b010);
    chk("cont_cnt3",  {16'd0, FRAME_CNT}, 32'd3);
    chk("cont_busy3", {31'd0, BUSY},      32'd0);

    // Start+stop together in IDLE stays idle
    step(0, 0, 0, 0, 0, 3'b011);
    step(0, 0, 0);
    chk("startstop_busy", {31'd0, BUSY}, 32'd0);
    frame(4, 4, 0, 0, 0);

    // Stop while armed returns to IDLE
    step(0, 0, 0, 0, 0, 3'b001);
    step(0, 0, 0, 0, 0, 3'b010);
    chk("arm_busy", {31'd0, BUSY}, 32'd1);
    step(0, 0, 0);
    chk("armstop_busy", {31'd0, BUSY}, 32'd0);
    frame(4, 4, 0, 0, 0);
    chk("armstop_cnt", {16'd0, FRAME_CNT}, 32'd3);

    // Reset in the middle of line 2
    step(0, 0, 0, 0, 0, 3'b101);
    step(1, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    for (int p = 0; p < 4; p++) step(0, 1, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    chk("midline_busy", {31'd0, BUSY}, 32'd1);
    do_reset();
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    chk("abort_cnt", {16'd0, FRAME_CNT}, 32'd0);
    step(0, 0, 0, 0, 0, 3'b101);
    frame(4, 4, 1, 0, 0);
    chk("recover_cnt", {16'd0, FRAME_CNT}, 32'd1);

    // Counter wrap
    do_reset();
    #1 force dut.fcnt_q = 16'hFFFF;
    #1 release dut.fcnt_q;
    chk("preload_cnt", {16'd0, FRAME_CNT}, 32'h0000FFFF);
    step(0, 0, 0, 0, 0, 3'b101);
    frame(4, 4, 1, 0, 0);
    chk("wrap_cnt", {16'd0, FRAME_CNT}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
